// File: rtl/ps2_host_tx.sv
// PS/2 host-to-device transmitter: inhibits the bus, issues a request-to-send,
// then shifts a command byte out on device-generated clocks and checks the ACK.
module ps2_host_tx #(
    parameter int unsigned INHIBIT_CYCLES = 5000,    // must be >= 1
    parameter int unsigned TIMEOUT_CYCLES = 1000000  // must be >= 1
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [7:0] din,
    input  logic       valid,
    output logic       ready,
    input  logic       ps2_clk_i,
    input  logic       ps2_data_i,
    output logic       ps2_clk_oe,
    output logic       ps2_data_oe,
    output logic       done,
    output logic       ack_err,
    output logic       timeout
);

    localparam int unsigned CNT_MAX =
        (INHIBIT_CYCLES > TIMEOUT_CYCLES) ? INHIBIT_CYCLES : TIMEOUT_CYCLES;
    localparam int unsigned CNT_W = $clog2(CNT_MAX + 1);

    // Terminal counts: a state lasting N cycles leaves when the counter shows N-1.
    localparam logic [CNT_W-1:0] INH_LAST = CNT_W'(INHIBIT_CYCLES - 1);
    localparam logic [CNT_W-1:0] TMO_LAST = CNT_W'(TIMEOUT_CYCLES - 1);

    localparam logic [2:0] StIdle    = 3'd0;
    localparam logic [2:0] StInhibit = 3'd1;
    localparam logic [2:0] StReq     = 3'd2;
    localparam logic [2:0] StSend    = 3'd3;
    localparam logic [2:0] StAck     = 3'd4;

    logic [2:0]       state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [8:0]       frame_q, frame_d;      // {parity, data}
    logic [3:0]       bit_idx_q, bit_idx_d;  // number of falling edges seen in SEND
    logic [2:0]       clk_sync_q;
    logic [1:0]       data_sync_q;
    logic             clk_oe_q, clk_oe_d;
    logic             data_oe_q, data_oe_d;
    logic             done_q, done_d;
    logic             ack_err_q, ack_err_d;
    logic             timeout_q, timeout_d;

    logic       clk_fe;
    logic       tmo_hit;
    logic [9:0] frame_w;
    logic       send_bit;

    assign clk_fe   = clk_sync_q[2] & ~clk_sync_q[1];
    assign tmo_hit  = (cnt_q == TMO_LAST);
    assign frame_w  = {1'b1, frame_q};
    assign send_bit = frame_w[bit_idx_q];

    assign ready       = (state_q == StIdle);
    assign ps2_clk_oe  = clk_oe_q;
    assign ps2_data_oe = data_oe_q;
    assign done        = done_q;
    assign ack_err     = ack_err_q;
    assign timeout     = timeout_q;

    // Bring the asynchronous bus lines into the clk domain.
    always_ff @(posedge clk) begin
        if (rst) begin
            clk_sync_q  <= 3'b111;
            data_sync_q <= 2'b11;
        end else begin
            clk_sync_q  <= {clk_sync_q[1:0], ps2_clk_i};
            data_sync_q <= {data_sync_q[0], ps2_data_i};
        end
    end

    // Next-state logic for the transfer sequencer and its registered line drives.
    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q + CNT_W'(1);
        frame_d   = frame_q;
        bit_idx_d = bit_idx_q;
        clk_oe_d  = clk_oe_q;
        data_oe_d = data_oe_q;
        done_d    = 1'b0;
        ack_err_d = ack_err_q;
        timeout_d = timeout_q;

        case (state_q)
            StIdle: begin
                cnt_d     = '0;
                clk_oe_d  = 1'b0;
                data_oe_d = 1'b0;
                if (valid) begin
                    frame_d   = {~^din, din};
                    ack_err_d = 1'b0;
                    timeout_d = 1'b0;
                    clk_oe_d  = 1'b1;
                    state_d   = StInhibit;
                end
            end
            StInhibit: begin
                if (cnt_q == INH_LAST) begin
                    data_oe_d = 1'b1;  // start bit
                    cnt_d     = '0;
                    state_d   = StReq;
                end
            end
            StReq: begin
                if (tmo_hit) begin
                    clk_oe_d  = 1'b0;
                    data_oe_d = 1'b0;
                    timeout_d = 1'b1;
                    done_d    = 1'b1;
                    cnt_d     = '0;
                    state_d   = StIdle;
                end else begin
                    clk_oe_d  = 1'b0;  // hand the clock to the device, keep start bit
                    bit_idx_d = '0;
                    cnt_d     = '0;
                    state_d   = StSend;
                end
            end
            StSend: begin
                if (clk_fe) begin
                    cnt_d     = '0;
                    data_oe_d = ~send_bit;
                    if (bit_idx_q == 4'd9) begin
                        state_d = StAck;  // stop bit (1) leaves data released
                    end else begin
                        bit_idx_d = bit_idx_q + 4'd1;
                    end
                end else if (tmo_hit) begin
                    clk_oe_d  = 1'b0;
                    data_oe_d = 1'b0;
                    timeout_d = 1'b1;
                    done_d    = 1'b1;
                    cnt_d     = '0;
                    state_d   = StIdle;
                end
            end
            StAck: begin
                if (clk_fe) begin
                    ack_err_d = data_sync_q[1];
                    done_d    = 1'b1;
                    cnt_d     = '0;
                    state_d   = StIdle;
                end else if (tmo_hit) begin
                    clk_oe_d  = 1'b0;
                    data_oe_d = 1'b0;
                    timeout_d = 1'b1;
                    done_d    = 1'b1;
                    cnt_d     = '0;
                    state_d   = StIdle;
                end
            end
            default: begin
                clk_oe_d  = 1'b0;
                data_oe_d = 1'b0;
                cnt_d     = '0;
                state_d   = StIdle;
            end
        endcase
    end

    // Sequencer state, counters and registered outputs.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= StIdle;
            cnt_q     <= '0;
            frame_q   <= '0;
            bit_idx_q <= '0;
            clk_oe_q  <= 1'b0;
            data_oe_q <= 1'b0;
            done_q    <= 1'b0;
            ack_err_q <= 1'b0;
            timeout_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            frame_q   <= frame_d;
            bit_idx_q <= bit_idx_d;
            clk_oe_q  <= clk_oe_d;
            data_oe_q <= data_oe_d;
            done_q    <= done_d;
            ack_err_q <= ack_err_d;
            timeout_q <= timeout_d;
        end
    end

endmodule

// File: doc/ps2_host_tx.md
PS2_HOST_TX -- requirements
Module: ps2_host_tx

Interface
REQ-001 Parameter INHIBIT_CYCLES, default 5000, clock cycles ps2 clock is held low before a request (100 us at 50 MHz).
REQ-002 Parameter TIMEOUT_CYCLES, default 1000000, max cycles allowed between device clock falling edges (20 ms at 50 MHz).
REQ-003 clk  in  1  system clock; single clock domain, all state changes on rising edge.
REQ-004 rst  in  1  reset; synchronous, active-high.
REQ-005 din  in  8  command byte to send to the device.
REQ-006 valid  in  1  start request; accepted only when ready=1.
REQ-007 ready  out  1  high only in IDLE.
REQ-008 ps2_clk_i  in  1  raw ps2 clock line level (asynchronous).
REQ-009 ps2_data_i  in  1  raw ps2 data line level (asynchronous).
REQ-010 ps2_clk_oe  out  1  1 = pull ps2 clock line low; 0 = release.
REQ-011 ps2_data_oe  out  1  1 = pull ps2 data line low; 0 = release.
REQ-012 done  out  1  one-cycle pulse when a transfer ends (success, nack or timeout).
REQ-013 ack_err  out  1  registered; set with done when the device acknowledge is missing; cleared on the next accepted request.
REQ-014 timeout  out  1  registered; set with done on timeout; cleared on the next accepted request.

Function
REQ-015 ps2_clk_i shall pass through a 3-flop shift register sync <= {sync[1:0], ps2_clk_i}; falling edge fe = sync[2] & ~sync[1].
REQ-016 ps2_data_i shall pass through a 2-flop synchronizer before use.
REQ-017 FSM states: IDLE, INHIBIT, REQ, SEND, ACK.
REQ-018 IDLE: both oe=0, ready=1.
REQ-019 IDLE, valid=1: latch din, set parity = ~^din (odd parity), clear ack_err/timeout and cycle counter, go INHIBIT.
REQ-020 INHIBIT: clk_oe=1, data_oe=0 for exactly INHIBIT_CYCLES cycles, then REQ.
REQ-021 REQ: clk_oe=1, data_oe=1 (start bit) for exactly 1 cycle, then SEND with bit index 0.
REQ-022 SEND: clk_oe=0; frame = {1 (stop), parity, din[7:0]}, index 0 = din[0] (LSB first).
REQ-023 SEND: data_oe stays 1 (start bit) until the first fe.
REQ-024 SEND: on fe k (k=1..10), data_oe <= ~frame[k-1] on the next cycle; fe 10 releases data (stop bit).
REQ-025 SEND: after fe 10, go ACK with both oe=0.
REQ-026 ACK: on the next fe, sample synchronized data; 0 = success, 1 = ack_err=1; pulse done, go IDLE.
REQ-027 Cycle counter resets on state entry and on every fe in SEND/ACK.
REQ-028 Counter reaching TIMEOUT_CYCLES in REQ, SEND or ACK: release both lines, timeout=1, pulse done, go IDLE.
REQ-029 valid while ready=0 is ignored; din changes after acceptance do not affect the frame.
REQ-030 ack_err and timeout are never both 1; done is never asserted in IDLE without a completed transfer.
REQ-031 Counter width is sized for max(INHIBIT_CYCLES, TIMEOUT_CYCLES); no wrap before compare.

Reset
REQ-032 rst=1 at any cycle, including mid-frame: next state IDLE.
REQ-033 On reset: clk_oe=0, data_oe=0, done=0, ack_err=0, timeout=0, sync flops=all 1, counters=0.
REQ-034 After reset deasserts, ready=1 on the same cycle.

Verification (bench with INHIBIT_CYCLES=8, TIMEOUT_CYCLES=200, device model clocking at 20-cycle period)
REQ-035 din=0xED, valid pulse, device acks -> clk_oe high 8 cycles, 1-cycle REQ, bits 1,0,1,1,0,1,1,1, parity 1, stop 1, done=1, ack_err=0.
REQ-036 din=0xF4, device leaves data high at fe 11 -> parity bit 0, done=1, ack_err=1, timeout=0.
REQ-037 Device never clocks after REQ -> exactly 200 cycles later both oe=0, done=1, timeout=1.
REQ-038 rst asserted after fe 4 of a 0xFF transfer -> next cycle both oe=0, ready=1; new valid with din=0x00 sends a correct frame, parity 1.
REQ-039 valid held high with din changing during a transfer -> only the first byte is sent, exactly one done pulse.
